// File: rtl/apb_rr_interconnect.sv
// Many-to-many word interconnect: one round-robin arbiter and one output register per slave,
// with out-of-range destinations acknowledged, dropped and reported through a one-cycle error pulse.
module apb_rr_interconnect #(
  parameter int NUM_MASTERS = 4,
  parameter int NUM_SLAVES  = 2,
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 2
) (
  input  logic                          pclk,
  input  logic                          reset,
  input  logic [NUM_MASTERS-1:0]        valids,
  input  logic [DATA_WIDTH-1:0]         master_data [NUM_MASTERS],
  input  logic [ADDR_WIDTH-1:0]         dest_addrs  [NUM_MASTERS],
  output logic [NUM_MASTERS-1:0]        master_ready,
  output logic [NUM_SLAVES-1:0]         slave_valid,
  output logic [DATA_WIDTH-1:0]         slave_data  [NUM_SLAVES],
  input  logic [NUM_SLAVES-1:0]         slave_ready,
  output logic                          err_valid,
  output logic [$clog2(NUM_MASTERS)-1:0] err_master
);

  localparam int PW = $clog2(NUM_MASTERS);

  logic [PW-1:0]         rr_ptr  [NUM_SLAVES];
  logic [PW-1:0]         win_idx [NUM_SLAVES];
  logic [NUM_SLAVES-1:0] accept;
  logic                  err_now;
  logic [PW-1:0]         err_idx;

  // Master index base+k, wrapping at NUM_MASTERS (which need not be a power of two).
  function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int k);
    int s = int'(base) + k;
    if (s >= NUM_MASTERS) s -= NUM_MASTERS;
    return PW'(s);
  endfunction

  always_comb begin
    logic          found;
    logic [PW-1:0] idx;
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    master_ready = '0;
    accept       = '0;
    err_now      = 1'b0;
    err_idx      = '0;
    found        = 1'b0;
    idx          = '0;
    for (int j = 0; j < NUM_SLAVES; j++) begin
      win_idx[j] = '0;
      found      = 1'b0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
        idx = wrap_idx(rr_ptr[j], k);
        if (!found && valids[idx] && int'(dest_addrs[idx]) == j) begin
          found      = 1'b1;
          win_idx[j] = idx;
        end
      end
      // A stalled slave (holding a word nobody consumes) blocks its winner.
      accept[j] = found && (!slave_valid[j] || slave_ready[j]);
      if (accept[j]) master_ready[win_idx[j]] = 1'b1;
    end
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (valids[i] && int'(dest_addrs[i]) >= NUM_SLAVES) begin
        master_ready[i] = 1'b1;
        err_now         = 1'b1;
        err_idx         = PW'(i);
      end
    end
    if (reset) master_ready = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      // NOTE: slave_data is a small per-slave register bank, so it is reset along with the valids.
      slave_valid <= '0;
      slave_data  <= '{default: '0};
      rr_ptr      <= '{default: '0};
      err_valid   <= 1'b0;
      err_master  <= '0;
    end else begin
      for (int j = 0; j < NUM_SLAVES; j++) begin
        if (accept[j]) begin
          slave_valid[j] <= 1'b1;
          slave_data[j]  <= master_data[win_idx[j]];
          rr_ptr[j]      <= wrap_idx(win_idx[j], 1);
        end else if (slave_ready[j]) begin
          slave_valid[j] <= 1'b0;
        end
      end
      err_valid  <= err_now;
      err_master <= err_idx;
    end
  end

endmodule

// File: tb/tb_apb_rr_interconnect.sv
// Self-checking bench for apb_rr_interconnect (4 masters, 2 slaves, 8-bit data): directed
// scenarios followed by randomized traffic, all compared against a behavioural model.
module tb_apb_rr_interconnect;

  localparam int NM = 4;
  localparam int NS = 2;

  logic          pclk = 1'b0;
  logic          reset;
  logic [NM-1:0] valids;
  logic [7:0]    m_data [NM];
  logic [1:0]    m_addr [NM];
  logic [NM-1:0] master_ready;
  logic [NS-1:0] slave_valid;
  logic [7:0]    slave_data [NS];
  logic [NS-1:0] slave_ready;
  logic          err_valid;
  logic [1:0]    err_master;

  int checks = 0;
  int errors = 0;

  // Reference model state: round-robin pointers, slave registers, error report.
  int            ptr [NS];
  bit            mv  [NS];
  logic [7:0]    md  [NS];
  bit            ev;
  int            em;
  logic [NM-1:0] last_rdy;

  apb_rr_interconnect #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .DATA_WIDTH(8), .ADDR_WIDTH(2)) dut (
    .pclk(pclk), .reset(reset), .valids(valids), .master_data(m_data), .dest_addrs(m_addr),
    .master_ready(master_ready), .slave_valid(slave_valid), .slave_data(slave_data),
    .slave_ready(slave_ready), .err_valid(err_valid), .err_master(err_master)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < NS; j++) begin
      ptr[j] = 0; mv[j] = 0; md[j] = '0;
    end
    ev = 0; em = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".slave_valid"}, 32'(slave_valid), {30'd0, mv[1], mv[0]});
    for (int j = 0; j < NS; j++)
      if (mv[j]) check($sformatf("%s.slave_data%0d", tag, j), 32'(slave_data[j]), 32'(md[j]));
    check({tag, ".err_valid"}, 32'(err_valid), 32'(ev));
    if (ev) check({tag, ".err_master"}, 32'(err_master), em);
  endtask

  // One clock cycle: predict grants from current inputs, check them, clock, update model, check outputs.
  task automatic cycle(input string tag);
    int win [NS];
    bit acc [NS];
    int first_err;
    logic [NM-1:0] exp_rdy;
    exp_rdy = '0;
    first_err = -1;
    for (int j = 0; j < NS; j++) begin
      win[j] = -1;
      for (int k = 0; k < NM; k++) begin
        int i = (ptr[j] + k) % NM;
        if (win[j] < 0 && valids[i] && int'(m_addr[i]) == j) win[j] = i;
      end
      acc[j] = (win[j] >= 0) && (!mv[j] || slave_ready[j]);
      if (acc[j]) exp_rdy[win[j]] = 1'b1;
    end
    for (int i = 0; i < NM; i++)
      if (valids[i] && int'(m_addr[i]) >= NS) begin
        exp_rdy[i] = 1'b1;
        if (first_err < 0) first_err = i;
      end
    #2;
    check({tag, ".master_ready"}, 32'(master_ready), 32'(exp_rdy));
    last_rdy = exp_rdy;
    @(posedge pclk);
    #1;
    for (int j = 0; j < NS; j++) begin
      if (acc[j]) begin
        mv[j] = 1; md[j] = m_data[win[j]]; ptr[j] = (win[j] + 1) % NM;
      end else if (slave_ready[j]) begin
        mv[j] = 0;
      end
    end
    ev = (first_err >= 0);
    em = ev ? first_err : 0;
    check_outputs(tag);
  endtask

  int order [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    reset = 1'b1;
    valids = 4'b1111;
    slave_ready = 2'b11;
    for (int i = 0; i < NM; i++) begin
      m_data[i] = 8'(i); m_addr[i] = 2'd0;
    end
    model_reset();
    #2;
    check("reset.master_ready", 32'(master_ready), 32'd0);
    check_outputs("reset");
    @(posedge pclk);
    #1;
    valids = 4'b0000;
    reset = 1'b0;

    // Single word, master 0 to slave 1.
    valids = 4'b0001; m_addr[0] = 2'd1; m_data[0] = 8'hA5;
    cycle("single");
    check("single.data_a5", 32'(slave_data[1]), 32'hA5);

    // All four masters to slave 0: strict rotation.
    valids = 4'b1111;
    for (int i = 0; i < NM; i++) begin
      m_addr[i] = 2'd0; m_data[i] = 8'h10 + 8'(i);
    end
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("rotate%0d.grant", k), 32'(master_ready), 32'(1) << order[k]);
      cycle($sformatf("rotate%0d", k));
      check($sformatf("rotate%0d.order", k), 32'(slave_data[0]), 32'h10 + 32'(order[k]));
    end

    // Stall slave 0, then release it.
    slave_ready = 2'b10;
    cycle("stall0");
    cycle("stall1");
    slave_ready = 2'b11;
    cycle("unstall");

    // Parallel acceptance on both slaves.
    valids = 4'b0110; m_addr[1] = 2'd0; m_addr[2] = 2'd1;
    cycle("parallel");

    // Out-of-range destinations from masters 1 and 3.
    valids = 4'b0000;
    cycle("drain");
    valids = 4'b1010; m_addr[1] = 2'd3; m_addr[3] = 2'd3;
    cycle("oob");
    check("oob.err_master1", 32'(err_master), 32'd1);
    valids = 4'b0000;
    cycle("oob_end");

    // Randomized traffic; masters hold a request until it is accepted.
    last_rdy = '0;
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NM; i++)
        if (!valids[i] || last_rdy[i]) begin
          valids[i] = ($urandom_range(0, 3) != 0);
          m_addr[i] = ($urandom_range(0, 9) < 8) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
          m_data[i] = 8'($urandom);
        end
      slave_ready = 2'($urandom);
      cycle($sformatf("rand%0d", n));
    end

    // Asynchronous reset with both slaves holding words.
    valids = 4'b0000; slave_ready = 2'b11;
    cycle("pre_drain");
    valids = 4'b0011; m_addr[0] = 2'd0; m_addr[1] = 2'd1; slave_ready = 2'b00;
    cycle("fill");
    check("fill.both_valid", 32'(slave_valid), 32'd3);
    valids = 4'b1111;
    for (int i = 0; i < NM; i++) m_addr[i] = 2'd0;
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    check("async.master_ready", 32'(master_ready), 32'd0);
    check_outputs("async");
    @(posedge pclk);
    #1;
    reset = 1'b0;
    slave_ready = 2'b11;
    #1;
    check("post_reset.grant", 32'(master_ready), 32'b0001);
    cycle("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_rr_interconnect.md
APB_RR_INTERCONNECT -- requirements
Module: apb_rr_interconnect

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 4: number of master ports, legal range 2..16.
REQ-002 SHALL have parameter NUM_SLAVES, default 2: number of slave ports, legal range 1..16.
REQ-003 SHALL have parameter DATA_WIDTH, default 8: payload width in bits.
REQ-004 SHALL have parameter ADDR_WIDTH, default 2: destination address width, at least $clog2(NUM_SLAVES), minimum 1.
REQ-005 SHALL have port pclk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port valids, input, NUM_MASTERS bits: per-master request valid.
REQ-008 SHALL have port master_data, input, unpacked array [NUM_MASTERS] of DATA_WIDTH: per-master payload.
REQ-009 SHALL have port dest_addrs, input, unpacked array [NUM_MASTERS] of ADDR_WIDTH: per-master destination slave index.
REQ-010 SHALL have port master_ready, output, NUM_MASTERS bits: request accepted this cycle when valids[i] & master_ready[i].
REQ-011 SHALL have port slave_valid, output, NUM_SLAVES bits: slave output register holds data.
REQ-012 SHALL have port slave_data, output, unpacked array [NUM_SLAVES] of DATA_WIDTH: registered payload.
REQ-013 SHALL have port slave_ready, input, NUM_SLAVES bits: slave consumes the word when slave_valid[j] & slave_ready[j].
REQ-014 SHALL have port err_valid, output, 1 bit: one-cycle pulse for an out-of-range address.
REQ-015 SHALL have port err_master, output, $clog2(NUM_MASTERS) bits: index of the offending master, valid while err_valid=1.

Function
REQ-016 SHALL contain one independent round-robin arbiter per slave; its candidates are masters i with valids[i]=1 and dest_addrs[i]=j.
REQ-017 Arbiter j SHALL pick the first candidate at or after pointer rr_ptr[j], searching upward and wrapping from NUM_MASTERS-1 to 0.
REQ-018 Slave j SHALL accept a word when its winner exists and (slave_valid[j]=0 or slave_ready[j]=1); master_ready[winner]=1 combinationally in that same cycle.
REQ-019 master_ready[i] SHALL be 0 for every non-winning master and whenever slave j is stalled (slave_valid[j]=1, slave_ready[j]=0).
REQ-020 On acceptance, slave_data[j] and slave_valid[j]=1 SHALL update at the next pclk edge, giving 1-cycle latency; full throughput of 1 word/cycle/slave when slave_ready is held high.
REQ-021 On acceptance, rr_ptr[j] SHALL load (winner+1) mod NUM_MASTERS; with no acceptance it SHALL hold.
REQ-022 slave_valid[j] SHALL clear at a pclk edge where it is consumed and no new word is accepted; on simultaneous consume and accept it SHALL stay 1 with new data.
REQ-023 slave_data[j] SHALL stay stable while slave_valid[j]=1 and slave_ready[j]=0.
REQ-024 Different slaves SHALL accept in parallel in the same cycle; there is no cross-slave interaction.
REQ-025 A master with valids[i]=1 and dest_addrs[i]>=NUM_SLAVES SHALL get master_ready[i]=1 immediately; the word SHALL be dropped.
REQ-026 In that case err_valid SHALL pulse high for exactly the next cycle, with err_master set to the lowest such index; other simultaneous offenders are dropped without a report.
REQ-027 Masters SHALL hold valids, master_data and dest_addrs stable until accepted; the block does not check this.

Reset
REQ-028 While reset=1, asynchronously: slave_valid=0, slave_data=0, rr_ptr=0 for all slaves, err_valid=0, err_master=0.
REQ-029 master_ready SHALL be 0 during reset; words held in slave registers at reset assertion are discarded.
REQ-030 The first acceptance SHALL be possible at the first pclk edge after reset deasserts.

Verification
All scenarios use NUM_MASTERS=4, NUM_SLAVES=2, DATA_WIDTH=8.
REQ-031 Master 0, addr 1, data 0xA5, slave_ready=2'b11: master_ready[0]=1 in the same cycle; next cycle slave_valid[1]=1 and slave_data[1]=0xA5.
REQ-032 All four masters fixed at addr 0, slave_ready[0]=1: accepted masters are 0,1,2,3,0,1 on consecutive cycles, and slave_data[0] follows the same order.
REQ-033 slave_ready[0]=0 with slave_valid[0]=1: master_ready is 0 for addr-0 masters and slave_data[0] is frozen; raising slave_ready[0] lets the next word be accepted in that cycle.
REQ-034 Master 1 to addr 0 and master 2 to addr 1 in the same cycle: both master_ready bits are 1, and both slaves are valid next cycle.
REQ-035 Masters 1 and 3 both with addr 3: master_ready[1]=1 and master_ready[3]=1; next cycle err_valid=1 for 1 cycle with err_master=1; slave_valid stays 0.
REQ-036 Reset asserted mid-cycle while slave_valid=2'b11: slave_valid goes to 0 without waiting for a pclk edge; after release, with masters 0..3 requesting addr 0, master 0 wins first.
